// File: rtl/vga_timing_core.sv
// vga_timing_core: 640x480@60 raster timing (syncs, display enable, coordinates, frame-buffer address).
// Latency: all outputs are registered and describe the current counter position (no extra pipeline delay).
// Backpressure: none; free-running from the pixel clock, restartable by synchronous reset.
//
// Ports:
//   iVGA_CLK      pixel clock, all logic on its rising edge
//   iRST_n        synchronous active-low reset, restarts timing at (0,0)
//   oHS / oVS     active-low horizontal / vertical sync
//   oBLANK_n      high only in the visible region
//   oPIX_X/Y      coordinate inside the visible area, 0 while blanked
//   oFRAME_START  one-cycle pulse when the raster wraps to (0,0)
//   oADDR         linear pixel address y*H_ACTIVE+x; only built when the
//                 macro VGA_TIMING_ADDR_EN is defined, otherwise tied to 0
module vga_timing_core #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  output logic        oHS,
  output logic        oVS,
  output logic        oBLANK_n,
  output logic [9:0]  oPIX_X,
  output logic [9:0]  oPIX_Y,
  output logic        oFRAME_START,
  output logic [18:0] oADDR
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          h_wrap;
  logic          hs_nxt, vs_nxt, blank_n_nxt, frame_start_nxt;
  logic          h_act_nxt, v_act_nxt;
  logic [9:0]    pix_x_nxt, pix_y_nxt;

  // Outputs are decoded from the next counter value so that, once
  // registered, they line up with the counters on the same edge.
  always_comb begin
    h_wrap = (h_cnt == HW'(H_TOTAL - 1));
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end

    hs_nxt      = (int'(h_nxt) >= H_SYNC);
    vs_nxt      = (int'(v_nxt) >= V_SYNC);
    h_act_nxt   = (int'(h_nxt) >= H_ACT_START) && (int'(h_nxt) < H_ACT_END);
    v_act_nxt   = (int'(v_nxt) >= V_ACT_START) && (int'(v_nxt) < V_ACT_END);
    blank_n_nxt = h_act_nxt && v_act_nxt;

    pix_x_nxt = '0;
    pix_y_nxt = '0;
    if (blank_n_nxt) begin
      pix_x_nxt = 10'(int'(h_nxt) - H_ACT_START);
      pix_y_nxt = 10'(int'(v_nxt) - V_ACT_START);
    end

    frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      oHS          <= 1'b0;
      oVS          <= 1'b0;
      oBLANK_n     <= 1'b0;
      oPIX_X       <= '0;
      oPIX_Y       <= '0;
      oFRAME_START <= 1'b0;
    end else begin
      h_cnt        <= h_nxt;
      v_cnt        <= v_nxt;
      oHS          <= hs_nxt;
      oVS          <= vs_nxt;
      oBLANK_n     <= blank_n_nxt;
      oPIX_X       <= pix_x_nxt;
      oPIX_Y       <= pix_y_nxt;
      oFRAME_START <= frame_start_nxt;
    end
  end

`ifdef VGA_TIMING_ADDR_EN
  logic [18:0] addr;

  // Advance when leaving an active pixel (oBLANK_n describes the current
  // position), hold through blanking, clear on entering (0,0).
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      addr <= '0;
    end else if (frame_start_nxt) begin
      addr <= '0;
    end else if (oBLANK_n) begin
      addr <= addr + 19'd1;
    end
  end

  assign oADDR = addr;
`else
  assign oADDR = '0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed checks of vga_timing_core.
// A small-geometry instance (8x6 total) checks full-frame behaviour from a vector table;
// a default-geometry instance checks real 640x480 sync widths, blank timing and mid-line reset.
module tb_vga_timing_core;

  logic clk;
  logic rst_s, rst_b;

  logic        s_hs, s_vs, s_bl, s_fs;
  logic [9:0]  s_x, s_y;
  logic [18:0] s_addr;

  logic        b_hs, b_vs, b_bl, b_fs;
  logic [9:0]  b_x, b_y;
  logic [18:0] b_addr;

  // Small raster: H = 2 sync,1 back,4 active,1 front (8); V = 1,1,3,1 (6).
  vga_timing_core #(
    .H_SYNC(2), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)
  ) u_small (
    .iVGA_CLK(clk), .iRST_n(rst_s),
    .oHS(s_hs), .oVS(s_vs), .oBLANK_n(s_bl),
    .oPIX_X(s_x), .oPIX_Y(s_y), .oFRAME_START(s_fs), .oADDR(s_addr)
  );

  vga_timing_core u_big (
    .iVGA_CLK(clk), .iRST_n(rst_b),
    .oHS(b_hs), .oVS(b_vs), .oBLANK_n(b_bl),
    .oPIX_X(b_x), .oPIX_Y(b_y), .oFRAME_START(b_fs), .oADDR(b_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int fs_cnt = 0;

  typedef struct {
    int cyc;
    bit hs, vs, bl;
    int x, y;
    bit fs;
    int addr;
  } vec_t;

  vec_t vec[15];

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
    if (b_fs) fs_cnt++;
  endtask

  function automatic int addr_exp(input int a);
`ifdef VGA_TIMING_ADDR_EN
    return a;
`else
    return 0 * a;
`endif
  endfunction

  initial begin
    int hl, vl, n;

    // cycle after release, hs, vs, blank_n, x, y, frame_start, addr
    vec[0]  = '{0,  0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1,  0, 0, 0, 0, 0, 0, 0};
    vec[2]  = '{2,  1, 0, 0, 0, 0, 0, 0};
    vec[3]  = '{8,  0, 1, 0, 0, 0, 0, 0};
    vec[4]  = '{11, 1, 1, 0, 0, 0, 0, 0};
    vec[5]  = '{19, 1, 1, 1, 0, 0, 0, 0};
    vec[6]  = '{22, 1, 1, 1, 3, 0, 0, 3};
    vec[7]  = '{23, 1, 1, 0, 0, 0, 0, 4};
    vec[8]  = '{28, 1, 1, 1, 1, 1, 0, 5};
    vec[9]  = '{38, 1, 1, 1, 3, 2, 0, 11};
    vec[10] = '{39, 1, 1, 0, 0, 0, 0, 12};
    vec[11] = '{47, 1, 1, 0, 0, 0, 0, 12};
    vec[12] = '{48, 0, 0, 0, 0, 0, 1, 0};
    vec[13] = '{49, 0, 0, 0, 0, 0, 0, 0};
    vec[14] = '{67, 1, 1, 1, 0, 0, 0, 0};

    rst_s = 1'b0;
    rst_b = 1'b0;
    tick();
    tick();

    // ---------------- small raster, table driven ----------------
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 1) rst_s = 1'b1;
      while (k < vec[i].cyc) tick();
      chk($sformatf("s%0d_hs", vec[i].cyc), int'(s_hs), int'(vec[i].hs));
      chk($sformatf("s%0d_vs", vec[i].cyc), int'(s_vs), int'(vec[i].vs));
      chk($sformatf("s%0d_blank", vec[i].cyc), int'(s_bl), int'(vec[i].bl));
      chk($sformatf("s%0d_x", vec[i].cyc), int'(s_x), vec[i].x);
      chk($sformatf("s%0d_y", vec[i].cyc), int'(s_y), vec[i].y);
      chk($sformatf("s%0d_fs", vec[i].cyc), int'(s_fs), int'(vec[i].fs));
      chk($sformatf("s%0d_addr", vec[i].cyc), int'(s_addr), addr_exp(vec[i].addr));
    end

    // ---------------- default raster ----------------
    fs_cnt = 0;
    chk("rst_hs", int'(b_hs), 0);
    chk("rst_vs", int'(b_vs), 0);
    chk("rst_blank", int'(b_bl), 0);
    chk("rst_x", int'(b_x), 0);
    chk("rst_y", int'(b_y), 0);
    chk("rst_fs", int'(b_fs), 0);
    chk("rst_addr", int'(b_addr), 0);

    rst_b = 1'b1;
    k = 0;
    hl = 0;
    vl = 0;
    // Lines 0,1 fully and the first 100 clocks of line 2: 3 HS pulses of 96.
    for (int i = 0; i < 1700; i++) begin
      if (!b_hs) hl++;
      if (!b_vs) vl++;
      tick();
    end
    chk("hs_low_clocks", hl, 288);
    chk("vs_low_clocks", vl, 1600);

    while (!b_bl && k < 30000) tick();
    chk("blank_rise_edges", k, 28144);
    chk("first_px_x", int'(b_x), 0);
    chk("first_px_y", int'(b_y), 0);
    chk("first_px_addr", int'(b_addr), 0);

    n = 0;
    while (b_bl && n < 1000) begin n++; tick(); end
    chk("blank_high_run", n, 640);
    chk("blanked_x", int'(b_x), 0);
    chk("blanked_y", int'(b_y), 0);
    chk("addr_hold_blank", int'(b_addr), addr_exp(640));

    n = 0;
    while (!b_bl && n < 1000) begin n++; tick(); end
    chk("blank_low_run", n, 160);
    chk("line36_x", int'(b_x), 0);
    chk("line36_y", int'(b_y), 1);
    chk("line36_addr", int'(b_addr), addr_exp(640));

    // Mid-active-line reset at v=36, h=400.
    while (k < 29200) tick();
    chk("mid_blank", int'(b_bl), 1);
    chk("mid_x", int'(b_x), 256);
    chk("mid_y", int'(b_y), 1);
    chk("mid_addr", int'(b_addr), addr_exp(896));
    rst_b = 1'b0;
    tick();
    chk("mrst_hs", int'(b_hs), 0);
    chk("mrst_vs", int'(b_vs), 0);
    chk("mrst_blank", int'(b_bl), 0);
    chk("mrst_x", int'(b_x), 0);
    chk("mrst_y", int'(b_y), 0);
    chk("mrst_fs", int'(b_fs), 0);
    chk("mrst_addr", int'(b_addr), 0);
    tick();
    tick();
    rst_b = 1'b1;
    k = 0;
    tick();
    chk("post_rst_hs", int'(b_hs), 0);
    while (!b_bl && k < 30000) tick();
    chk("blank_rise_after_rst", k, 28144);
    chk("rerise_x", int'(b_x), 0);
    chk("rerise_y", int'(b_y), 0);

    // The first frame after reset never emits a frame-start pulse.
    chk("no_fs_first_frame", fs_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
